// File: rtl/cla_pkg.sv
// Shared types and lookahead helpers for the pipelined CLA adder.
// Helpers work on MAXG-wide vectors so one definition serves any GROUP/NGRP.
package cla_pkg;

   localparam int MAXG = 64;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   function automatic int ngrp(input int width, input int group);
      return width / group;
   endfunction

   // Combined propagate/generate of the lowest n positions; n = 0 gives identity (p=1, g=0).
   function automatic pg_t grp_pg(input logic [MAXG-1:0] p, input logic [MAXG-1:0] g,
                                  input int n);
      pg_t r;
      r.p = 1'b1;
      r.g = 1'b0;
      for (int i = 0; i < MAXG; i++) begin
         if (i < n) begin
            r.g = g[i] | (p[i] & r.g);
            r.p = r.p & p[i];
         end
      end
      return r;
   endfunction

   // Carry into block n, looked ahead directly from the block P/G terms and c0.
   function automatic logic block_carries(input logic [MAXG-1:0] bp, input logic [MAXG-1:0] bg,
                                          input logic c0, input int n);
      pg_t r;
      r = grp_pg(bp, bg, n);
      return r.g | (r.p & c0);
   endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit lookahead block: block P/G from bit p/g, and the carry into
// every bit of the block given the block carry-in.
module cla_group
   import cla_pkg::*;
#(
   parameter int GROUP = 8
) (
   input  logic [GROUP-1:0] p,
   input  logic [GROUP-1:0] g,
   input  logic             ci,
   output logic             bp,
   output logic             bg,
   output logic [GROUP-1:0] c
);

   always_comb begin
      logic [MAXG-1:0] pe;
      logic [MAXG-1:0] ge;
      pg_t             r;
      pe = '0;
      ge = '0;
      pe[GROUP-1:0] = p;
      ge[GROUP-1:0] = g;
      r  = grp_pg(pe, ge, GROUP);
      bp = r.p;
      bg = r.g;
      c  = '0;
      for (int i = 0; i < GROUP; i++) begin
         r    = grp_pg(pe, ge, i);
         c[i] = r.g | (r.p & ci);
      end
   end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready flow control.
// Define CLA_FLAGS_EN to add registered ovf/zero/neg outputs.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int GROUP  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CLA_FLAGS_EN
   ,
   output logic             ovf,
   output logic             zero,
   output logic             neg
`endif
);

   localparam int NGRP = ngrp(WIDTH, GROUP);

   if (WIDTH % GROUP != 0) begin : g_bad_group
      $fatal(1, "cla_pipe_adder: WIDTH must be a multiple of GROUP");
   end
   if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
      $fatal(1, "cla_pipe_adder: STAGES must be 1..3");
   end
   if (GROUP > MAXG || NGRP > MAXG) begin : g_too_wide
      $fatal(1, "cla_pipe_adder: GROUP and NGRP must not exceed MAXG");
   end

   // Handshake: a beat moves on a cycle where valid and ready are both high.
   // The whole pipe advances together (adv); in_ready is adv, so it is
   // combinational from out_ready, and a full pipe frees a slot in the same
   // cycle its output is taken.
   logic adv;
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   logic [WIDTH-1:0] bb, p0, g0;
   logic             c00;
   assign bb  = sub ? ~b : b;
   assign c00 = sub ? ~cin : cin;
   assign p0  = a ^ bb;
   assign g0  = a & bb;

   logic [NGRP-1:0] gp0, gg0;
   for (genvar gi = 0; gi < NGRP; gi++) begin : g_blk_pg
      cla_group #(.GROUP(GROUP)) u_pg (
         .p  (p0[gi*GROUP +: GROUP]),
         .g  (g0[gi*GROUP +: GROUP]),
         .ci (1'b0),
         .bp (gp0[gi]),
         .bg (gg0[gi]),
         .c  ()
      );
   end

   logic             v1, c01;
   logic [WIDTH-1:0] p1, g1;
   logic [NGRP-1:0]  gp1, gg1;
   if (STAGES == 3) begin : g_pg_reg
      always_ff @(posedge clk) begin
         if (rst)      v1 <= 1'b0;
         else if (adv) v1 <= in_valid;
      end
      always_ff @(posedge clk) begin
         if (adv) begin
            p1  <= p0;
            g1  <= g0;
            gp1 <= gp0;
            gg1 <= gg0;
            c01 <= c00;
         end
      end
   end else begin : g_pg_thru
      assign v1  = in_valid;
      assign p1  = p0;
      assign g1  = g0;
      assign gp1 = gp0;
      assign gg1 = gg0;
      assign c01 = c00;
   end

   logic [NGRP:0] bc;
   always_comb begin
      logic [MAXG-1:0] pe;
      logic [MAXG-1:0] ge;
      pe = '0;
      ge = '0;
      pe[NGRP-1:0] = gp1;
      ge[NGRP-1:0] = gg1;
      bc = '0;
      for (int j = 0; j <= NGRP; j++) bc[j] = block_carries(pe, ge, c01, j);
   end

   logic [WIDTH-1:0] cb;
   for (genvar gi = 0; gi < NGRP; gi++) begin : g_blk_c
      cla_group #(.GROUP(GROUP)) u_c (
         .p  (p1[gi*GROUP +: GROUP]),
         .g  (g1[gi*GROUP +: GROUP]),
         .ci (bc[gi]),
         .bp (),
         .bg (),
         .c  (cb[gi*GROUP +: GROUP])
      );
   end

   logic             v2, co2;
   logic [WIDTH-1:0] p2, c2;
   if (STAGES >= 2) begin : g_c_reg
      always_ff @(posedge clk) begin
         if (rst)      v2 <= 1'b0;
         else if (adv) v2 <= v1;
      end
      always_ff @(posedge clk) begin
         if (adv) begin
            p2  <= p1;
            c2  <= cb;
            co2 <= bc[NGRP];
         end
      end
   end else begin : g_c_thru
      assign v2  = v1;
      assign p2  = p1;
      assign c2  = cb;
      assign co2 = bc[NGRP];
   end

   logic [WIDTH-1:0] sum_n;
   assign sum_n = p2 ^ c2;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
`ifdef CLA_FLAGS_EN
         ovf       <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
`endif
      end else if (adv) begin
         out_valid <= v2;
         if (v2) begin
            sum  <= sum_n;
            cout <= co2;
`ifdef CLA_FLAGS_EN
            // Signed overflow: carry into the MSB disagrees with carry out of it.
            ovf  <= c2[WIDTH-1] ^ co2;
            zero <= ~|sum_n;
            neg  <= sum_n[WIDTH-1];
`endif
         end
      end
   end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed table, stall/reset sequences and a random stream against a behavioural model.
// Flag outputs are checked when CLA_FLAGS_EN is defined.
module tb_cla_pipe_adder;

   localparam int W      = 32;
   localparam int GROUP  = 8;
   localparam int STAGES = 2;
   localparam int EW     = W + 4;
   localparam int NV     = 13;

   logic         clk, rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
   logic [W-1:0] a, b, sum;
`ifdef CLA_FLAGS_EN
   logic         ovf, zero, neg;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Expected word: {ovf, zero, neg, cout, sum}
   logic [EW-1:0] exp_q[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
      logic         ze;
      logic         ng;
   } vec_t;

   vec_t vecs[NV];

   cla_pipe_adder #(.WIDTH(W), .GROUP(GROUP), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef CLA_FLAGS_EN
      ,
      .ovf       (ovf),
      .zero      (zero),
      .neg       (neg)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [EW-1:0] pack_vec(input vec_t v);
      return {v.ov, v.ze, v.ng, v.co, v.s};
   endfunction

   function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
      logic [W:0] r;
      logic       ov;
      if (!msub) begin
         r  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
         ov = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
      end else begin
         r    = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mcin};
         r[W] = ~r[W];
         ov   = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
      end
      return {ov, (r[W-1:0] == '0), r[W-1], r[W], r[W-1:0]};
   endfunction

   // driver tasks (called at a falling edge)
   task automatic set_inputs(input vec_t v);
      a   = v.a;
      b   = v.b;
      cin = v.cin;
      sub = v.sub;
   endtask

   task automatic send_beat(input logic [EW-1:0] e);
      bit done = 0;
      in_valid = 1'b1;
      for (int t = 0; t < 100 && !done; t++) begin
         #1;
         if (in_ready) begin
            exp_q.push_back(e);
            done = 1;
         end
         @(negedge clk);
      end
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1");
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // scoreboard
   always @(negedge clk) begin
      logic [EW-1:0] e;
      #2;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_out: got sum %0h, expected no result", sum);
         end else begin
            e = exp_q.pop_front();
            check("sum", 64'(sum), 64'(e[W-1:0]));
            check("cout", 64'(cout), 64'(e[W]));
`ifdef CLA_FLAGS_EN
            check("neg", 64'(neg), 64'(e[W+1]));
            check("zero", 64'(zero), 64'(e[W+2]));
            check("ovf", 64'(ovf), 64'(e[W+3]));
`endif
         end
      end
   end

   initial begin
      int            lat;
      bit            acc;
      logic [W-1:0]  ra, rb;
      logic          rc, rs;

      //            a             b             cin   sub   sum           co    ov    ze    ng
      vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef CLA_FLAGS_EN
      check("rst_flags", 64'({ovf, zero, neg}), 64'd0);
`endif
      rst = 1'b0;

      // single beat: latency
      set_inputs(vecs[0]);
      send_beat(pack_vec(vecs[0]));
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'(STAGES));
      wait_drain();

      // table, back to back
      for (int i = 0; i < NV; i++) begin
         set_inputs(vecs[i]);
         send_beat(pack_vec(vecs[i]));
      end
      wait_drain();

      // backpressure: hold out_ready low while three beats queue up
      out_ready = 1'b0;
      set_inputs(vecs[4]); in_valid = 1'b1; #1;
      check("stall_rdy0", 64'(in_ready), 64'd1);
      exp_q.push_back(pack_vec(vecs[4]));
      @(negedge clk);
      set_inputs(vecs[1]); #1;
      check("stall_rdy1", 64'(in_ready), 64'd1);
      exp_q.push_back(pack_vec(vecs[1]));
      @(negedge clk);
      set_inputs(vecs[5]); #1;
      check("stall_full", 64'(in_ready), 64'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_sum", 64'(sum), 64'(vecs[4].s));
         check("stall_cout", 64'(cout), 64'(vecs[4].co));
      end
      @(negedge clk);
      out_ready = 1'b1; #1;
      check("release_rdy", 64'(in_ready), 64'd1);
      exp_q.push_back(pack_vec(vecs[5]));
      @(negedge clk);
      in_valid = 1'b0;
      wait_drain();

      // reset with two beats in flight
      set_inputs(vecs[6]); in_valid = 1'b1; #1;
      exp_q.push_back(pack_vec(vecs[6]));
      @(negedge clk);
      set_inputs(vecs[7]); #1;
      exp_q.push_back(pack_vec(vecs[7]));
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_sum", 64'(sum), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("post_rst_idle", 64'(out_valid), 64'd0);
      end

      // random stream with random backpressure
      acc = 0;
      for (int k = 0; k < 400; k++) begin
         if (acc) in_valid = 1'b0;
         acc = 0;
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid && $urandom_range(0, 4) != 0) begin
            ra = $urandom(); rb = $urandom();
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            a = ra; b = rb; cin = rc; sub = rs;
            in_valid = 1'b1;
         end
         #1;
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, cin, sub));
            acc = 1;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
